// File: rtl/dac_spi_pkg.sv
// -----------------------------------------------------------------------------
// dac_spi_pkg
// Shared definitions for the DAC8734 multicast SPI frame engine:
//   - state_t        : engine FSM states
//   - DAC8734_*      : DAC8734 frame layout (24-bit frame, R/W bit 23,
//                      address field [20:16], data field [15:0])
//   - params_ok()    : legality check used at elaboration by the top level
//   - max3()         : helper for sizing the shared wait counter
// -----------------------------------------------------------------------------
package dac_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    LDAC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DAC8734_FRAME_BITS = 24;
  localparam int DAC8734_RW_BIT     = 23;
  localparam int DAC8734_ADDR_MSB   = 20;
  localparam int DAC8734_ADDR_LSB   = 16;
  localparam int DAC8734_DATA_MSB   = 15;
  localparam int DAC8734_DATA_LSB   = 0;

  // Every timing parameter needs at least one clock, and a frame needs at
  // least two bits so the shift register has something to shift into.
  function automatic bit params_ok(input int frame_bits, input int sclk_div,
                                   input int cs_setup, input int cs_hold,
                                   input int ldac_width);
    return (frame_bits >= 2) && (sclk_div >= 1) && (cs_setup >= 1) &&
           (cs_hold >= 1) && (ldac_width >= 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dac_spi_lane.sv
// -----------------------------------------------------------------------------
// dac_spi_lane
// One SPI output lane. Holds the lane-select bit and the frame shift register
// for the current command and registers the csb/sclk/sdo pins. All sequencing
// comes from shared strobes issued by the engine FSM.
//
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   load          : capture load_sel/load_frame (command accept)
//   load_sel      : this lane is selected by the command mask
//   load_frame    : frame to send, MSB first
//   shift         : advance to the next frame bit (start of an SCLK high phase)
//   cs_on         : chip select asserted for selected lanes next cycle
//   sclk_hi       : SCLK high next cycle for selected lanes
//   csb/sclk/sdo  : registered lane pins (csb active low, sclk idle low)
// -----------------------------------------------------------------------------
module dac_spi_lane
  import dac_spi_pkg::*;
#(
  parameter int FRAME_BITS = DAC8734_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  load_sel,
  input  logic [FRAME_BITS-1:0] load_frame,
  input  logic                  shift,
  input  logic                  cs_on,
  input  logic                  sclk_hi,
  output logic                  csb,
  output logic                  sclk,
  output logic                  sdo
);

  logic                  sel_q;
  logic                  sel_d;
  logic [FRAME_BITS-1:0] sr_q;
  logic [FRAME_BITS-1:0] sr_d;

  // Pins are registered from the *next* register contents so that the pin
  // changes on the same edge as the FSM state that asks for it.
  always_comb begin
    sel_d = sel_q;
    sr_d  = sr_q;
    if (load) begin
      sel_d = load_sel;
      sr_d  = load_frame;
    end else if (shift) begin
      sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q <= 1'b0;
      sr_q  <= '0;
      csb   <= 1'b1;
      sclk  <= 1'b0;
      sdo   <= 1'b0;
    end else begin
      sel_q <= sel_d;
      sr_q  <= sr_d;
      csb   <= !(cs_on && sel_d);
      sclk  <= sclk_hi && sel_d;
      sdo   <= cs_on && sel_d && sr_d[FRAME_BITS-1];
    end
  end

endmodule

// File: rtl/dac_spi_multicast.sv
// -----------------------------------------------------------------------------
// dac_spi_multicast
// Multi-lane SPI frame engine for DAC8734 devices. One command carries a lane
// mask and one frame per lane; all selected frames are shifted out in
// parallel, optionally followed by a shared LDACB pulse.
//
// Build option: define DAC_SPI_AUTO_LDAC_EN to enable the LDAC state and honour
// s_ldac_req. Without it s_ldac_req is ignored and ldacb stays high.
//
// Handshake: a command is accepted on a rising edge where s_valid && s_ready.
// s_ready is high only in IDLE; s_mask/s_data/s_ldac_req are sampled on that
// edge and ignored at all other times.
//
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset
//   s_valid      : command valid
//   s_ready      : engine idle (command accepted on s_valid && s_ready)
//   s_mask       : lane select, bit i enables lane i
//   s_data       : lane i frame at [i*FRAME_BITS +: FRAME_BITS]
//   s_ldac_req   : pulse LDACB after the frames
//   busy         : high from the cycle after accept until DONE
//   done         : one-cycle completion pulse
//   csb/sclk/sdo : per-lane SPI pins
//   ldacb        : shared load strobe, active low
// -----------------------------------------------------------------------------
module dac_spi_multicast
  import dac_spi_pkg::*;
#(
  parameter int N_DAC      = 8,
  parameter int FRAME_BITS = DAC8734_FRAME_BITS,
  parameter int SCLK_DIV   = 2,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int LDAC_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [N_DAC-1:0]            s_mask,
  input  logic [N_DAC*FRAME_BITS-1:0] s_data,
  input  logic                        s_ldac_req,
  output logic                        busy,
  output logic                        done,
  output logic [N_DAC-1:0]            csb,
  output logic [N_DAC-1:0]            sclk,
  output logic [N_DAC-1:0]            sdo,
  output logic                        ldacb
);

  if (!params_ok(FRAME_BITS, SCLK_DIV, CS_SETUP, CS_HOLD, LDAC_WIDTH)) begin : g_param_err
    $error("dac_spi_multicast: illegal parameter set");
  end

`ifdef DAC_SPI_AUTO_LDAC_EN
  localparam bit LDAC_ON = 1'b1;
`else
  localparam bit LDAC_ON = 1'b0;
`endif

  localparam int WAIT_MAX = max3(CS_SETUP, CS_HOLD, LDAC_WIDTH);
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int PH_W     = $clog2(SCLK_DIV + 1);
  localparam int BIT_W    = $clog2(FRAME_BITS + 1);

  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);
  localparam logic [WAIT_W-1:0] LDAC_LAST  = WAIT_W'(LDAC_WIDTH - 1);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic [PH_W-1:0]   phase_cnt, phase_d;
  logic              phase_hi, phase_hi_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic              ldac_req_q, ldac_req_d;

  logic load, shift, cs_on, sclk_hi;
  logic busy_d, done_d, ldacb_d;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      phase_cnt  <= '0;
      phase_hi   <= 1'b0;
      bit_cnt    <= '0;
      ldac_req_q <= 1'b0;
    end else begin
      state      <= next_state;
      wait_cnt   <= wait_d;
      phase_cnt  <= phase_d;
      phase_hi   <= phase_hi_d;
      bit_cnt    <= bit_d;
      ldac_req_q <= ldac_req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic. Counters stop at their terminal value and
  // the state advances instead of wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    wait_d     = wait_cnt;
    phase_d    = phase_cnt;
    phase_hi_d = phase_hi;
    bit_d      = bit_cnt;
    ldac_req_d = ldac_req_q;
    case (state)
      IDLE: begin
        if (s_valid) begin
          ldac_req_d = s_ldac_req;
          wait_d     = '0;
          if (s_mask == '0) next_state = (LDAC_ON && s_ldac_req) ? LDAC : DONE;
          else              next_state = SETUP;
        end
      end
      SETUP: begin
        if (wait_cnt == SETUP_LAST) begin
          next_state = SHIFT;
          phase_d    = '0;
          phase_hi_d = 1'b1;
          bit_d      = '0;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (phase_cnt == PH_LAST) begin
          phase_d = '0;
          if (phase_hi) begin
            phase_hi_d = 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            next_state = HOLD;
            wait_d     = '0;
          end else begin
            bit_d      = bit_cnt + 1'b1;
            phase_hi_d = 1'b1;
          end
        end else begin
          phase_d = phase_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (wait_cnt == HOLD_LAST) begin
          wait_d     = '0;
          next_state = (LDAC_ON && ldac_req_q) ? LDAC : DONE;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      LDAC: begin
        if (wait_cnt == LDAC_LAST) next_state = DONE;
        else                       wait_d = wait_cnt + 1'b1;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Everything is decoded from the next state so the
  // registered pins line up with the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin
    load    = (state == IDLE) && s_valid;
    cs_on   = (next_state == SETUP) || (next_state == SHIFT) || (next_state == HOLD);
    sclk_hi = (next_state == SHIFT) && phase_hi_d;
    // New data bit only when a low phase ends and another bit follows, so sdo
    // moves together with the SCLK rise and is stable across the fall.
    shift   = (state == SHIFT) && !phase_hi && (phase_cnt == PH_LAST) &&
              (bit_cnt != BIT_LAST);
    busy_d  = (next_state != IDLE) && (next_state != DONE);
    done_d  = (next_state == DONE);
    ldacb_d = (next_state != LDAC);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      ldacb <= 1'b1;
    end else begin
      busy  <= busy_d;
      done  <= done_d;
      ldacb <= ldacb_d;
    end
  end

  assign s_ready = (state == IDLE);

  for (genvar i = 0; i < N_DAC; i++) begin : g_lane
    dac_spi_lane #(
      .FRAME_BITS (FRAME_BITS)
    ) u_lane (
      .clk        (clk),
      .resetn     (resetn),
      .load       (load),
      .load_sel   (s_mask[i]),
      .load_frame (s_data[i*FRAME_BITS +: FRAME_BITS]),
      .shift      (shift),
      .cs_on      (cs_on),
      .sclk_hi    (sclk_hi),
      .csb        (csb[i]),
      .sclk       (sclk[i]),
      .sdo        (sdo[i])
    );
  end

endmodule
